// File: rtl/cc_pkg.sv
// Shared definitions for the colour-correction coefficient loader.
//   COEF_NUM    : number of matrix coefficients (3x4 matrix)
//   A11..A34    : coefficient indices in row-major order
//   cc_state_e  : loader FSM state encoding
//   fixed_one() : builds the fixed-point value 1.0 for a given format
package cc_pkg;

  localparam int COEF_NUM = 12;

  localparam logic [3:0] A11 = 4'd0;
  localparam logic [3:0] A12 = 4'd1;
  localparam logic [3:0] A13 = 4'd2;
  localparam logic [3:0] A14 = 4'd3;
  localparam logic [3:0] A21 = 4'd4;
  localparam logic [3:0] A22 = 4'd5;
  localparam logic [3:0] A23 = 4'd6;
  localparam logic [3:0] A24 = 4'd7;
  localparam logic [3:0] A31 = 4'd8;
  localparam logic [3:0] A32 = 4'd9;
  localparam logic [3:0] A33 = 4'd10;
  localparam logic [3:0] A34 = 4'd11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RD_SEL  = 3'd2,
    RD_WAIT = 3'd3,
    RD_CAP  = 3'd4
  } cc_state_e;

  // Sign-magnitude word with sign 0, integer part 1, fraction 0.
  // A format without integer bits cannot represent 1.0, so it yields 0.
  function automatic logic [63:0] fixed_one(input int px_width, input int fract_width);
    logic [63:0] one;
    if (px_width > 0) begin
      one = 64'd1 << fract_width;
    end else begin
      one = 64'd0;
    end
    return one;
  endfunction

endpackage

// File: rtl/cc_ctrl_if.sv
// Control bus between the coefficient loader (master) and the
// colour-correction core (slave).
//   coef_sel  : coefficient index (load target or readback index)
//   coef      : coefficient word to write while coef_lock is high
//   coef_lock : write strobe, high only while a load is streaming
//   cur_coef  : slave's registered view of coefficient[coef_sel],
//               valid one cycle after coef_sel
interface cc_ctrl_if #(
  parameter int W = 32
);
  logic [3:0]   coef_sel;
  logic [W-1:0] coef;
  logic         coef_lock;
  logic [W-1:0] cur_coef;

  modport master (output coef_sel, output coef, output coef_lock, input cur_coef);
  modport slave  (input coef_sel, input coef, input coef_lock, output cur_coef);
endinterface

// File: rtl/cc_coef_loader.sv
// Coefficient loader: the host writes a shadow bank at any time, a commit
// arms a load, and the next start-of-frame snapshots the shadow bank and
// streams it to the core, so a frame never sees a half-updated matrix.
// A readback path fetches the coefficient the core is actually using.
// Ports:
//   clk_i, rst_i                   : clock, synchronous active-high reset
//   wr_i, wr_sel_i, wr_data_i      : shadow write (index 0..11, sign-magnitude)
//   commit_i                       : arm a load at the next frame start
//   sof_i                          : start-of-frame pulse
//   rd_req_i, rd_sel_i, rd_ready_o : readback request handshake
//   rd_valid_o, rd_data_o          : readback result strobe and data
//   busy_o, load_done_o            : load in progress / completion pulse
//   cc_ctrl_o                      : control bus towards the core
module cc_coef_loader
  import cc_pkg::*;
#(
  parameter int PX_WIDTH    = 10,
  parameter int FRACT_WIDTH = 10,
  parameter int CTRL_W      = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            wr_i,
  input  logic [3:0]                      wr_sel_i,
  input  logic [PX_WIDTH+FRACT_WIDTH:0]   wr_data_i,
  input  logic                            commit_i,
  input  logic                            sof_i,
  input  logic                            rd_req_i,
  input  logic [3:0]                      rd_sel_i,
  output logic                            rd_ready_o,
  output logic                            rd_valid_o,
  output logic [PX_WIDTH+FRACT_WIDTH:0]   rd_data_o,
  output logic                            busy_o,
  output logic                            load_done_o,
  cc_ctrl_if.master                       cc_ctrl_o
);

  localparam int COEF_WIDTH = PX_WIDTH + FRACT_WIDTH;
  localparam int WORD_W     = COEF_WIDTH + 1;
  localparam logic [WORD_W-1:0] COEF_ONE = WORD_W'(fixed_one(PX_WIDTH, FRACT_WIDTH));
  localparam logic [3:0] LAST_IDX = 4'(COEF_NUM - 1);

  // Identity matrix: 1.0 on the diagonal, 0 elsewhere (offsets included).
  function automatic logic [WORD_W-1:0] identity_word(input int idx);
    logic [WORD_W-1:0] w;
    if (idx == int'(A11) || idx == int'(A22) || idx == int'(A33)) begin
      w = COEF_ONE;
    end else begin
      w = '0;
    end
    return w;
  endfunction

  cc_state_e         state;
  logic              pending;
  logic              rd_zero;
  logic [WORD_W-1:0] shadow  [COEF_NUM];
  logic [WORD_W-1:0] staging [COEF_NUM];
  logic              load_start;

  // A load wins over a readback request arriving in the same cycle.
  assign load_start = (state == IDLE) && sof_i && pending;
  assign rd_ready_o = (state == IDLE) && !load_start;

  // Only the low WORD_W bits of cur_coef carry a coefficient.
  if (CTRL_W > WORD_W) begin : g_cur_hi
    logic unused_cur_hi;
    assign unused_cur_hi = ^cc_ctrl_o.cur_coef[CTRL_W-1:WORD_W];
  end

  // Host-facing shadow bank, writable in every state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < COEF_NUM; i++) begin
        shadow[i] <= identity_word(i);
      end
    end else if (wr_i && (wr_sel_i <= LAST_IDX)) begin
      shadow[wr_sel_i] <= wr_data_i;
    end
  end

  // Loader/readback FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state                <= IDLE;
      pending              <= 1'b0;
      rd_zero              <= 1'b0;
      busy_o               <= 1'b0;
      load_done_o          <= 1'b0;
      rd_valid_o           <= 1'b0;
      rd_data_o            <= '0;
      cc_ctrl_o.coef_lock  <= 1'b0;
      cc_ctrl_o.coef_sel   <= 4'd0;
      cc_ctrl_o.coef       <= '0;
      for (int i = 0; i < COEF_NUM; i++) begin
        staging[i] <= identity_word(i);
      end
    end else begin
      load_done_o <= 1'b0;
      rd_valid_o  <= 1'b0;

      // A commit coinciding with a load start arms the following frame.
      if (commit_i) begin
        pending <= 1'b1;
      end else if (load_start) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (load_start) begin
            // The staging copy freezes the load; the first word comes
            // straight from the shadow since staging updates this edge.
            staging             <= shadow;
            state               <= LOAD;
            busy_o              <= 1'b1;
            cc_ctrl_o.coef_lock <= 1'b1;
            cc_ctrl_o.coef_sel  <= 4'd0;
            cc_ctrl_o.coef      <= CTRL_W'(shadow[0]);
          end else if (rd_req_i) begin
            state              <= RD_SEL;
            cc_ctrl_o.coef_sel <= rd_sel_i;
            rd_zero            <= (rd_sel_i > LAST_IDX);
          end
        end
        LOAD: begin
          if (cc_ctrl_o.coef_sel == LAST_IDX) begin
            state               <= IDLE;
            busy_o              <= 1'b0;
            load_done_o         <= 1'b1;
            cc_ctrl_o.coef_lock <= 1'b0;
          end else begin
            cc_ctrl_o.coef_sel <= cc_ctrl_o.coef_sel + 4'd1;
            cc_ctrl_o.coef     <= CTRL_W'(staging[cc_ctrl_o.coef_sel + 4'd1]);
          end
        end
        RD_SEL: begin
          // The core registers cur_coef one cycle after coef_sel.
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          state      <= RD_CAP;
          rd_valid_o <= 1'b1;
          rd_data_o  <= rd_zero ? '0 : cc_ctrl_o.cur_coef[WORD_W-1:0];
        end
        RD_CAP: begin
          state <= IDLE;
        end
        default: begin
          state               <= IDLE;
          busy_o              <= 1'b0;
          cc_ctrl_o.coef_lock <= 1'b0;
        end
      endcase
    end
  end

endmodule
